icache_refill: RTL and testbench

- Miss-service engine directly downstream of the instruction cache.
- On a cache miss it arbitrates for the byte-wide RAM port and reads the 16-byte aligned block containing the missing PC.
- It assembles the bytes into a 128-bit line and returns it to the cache with a one-cycle update strobe carrying index and tag.
- Read-only master; the data-side memory path shares the RAM through an external arbiter (req/gnt).

---
 rtl/icache_refill.sv | 132 +++++++++++++
 tb/tb_icache_refill.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction-cache miss engine: fetches the aligned 16-byte block holding the
// missing PC over a shared byte-wide RAM port and returns it as one line.
//
// state | meaning
// IDLE  | waiting for a miss; latches block base, index and tag
// REQ   | requesting the RAM port, waiting for grant
// READ  | issuing byte addresses and collecting bytes one cycle later
// DONE  | one-cycle update strobe, line/index/tag presented to the cache
module icache_refill #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_BYTES = 16,
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 24
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     miss_en,
    input  logic [ADDR_WIDTH-1:0]    miss_pc,
    output logic                     mem_req,
    input  logic                     mem_gnt,
    output logic [ADDR_WIDTH-1:0]    mem_a,
    output logic                     mem_wr,
    input  logic [7:0]               mem_din,
    output logic                     update,
    output logic [8*BLOCK_BYTES-1:0] blk_out,
    output logic [INDEX_WIDTH-1:0]   idx_out,
    output logic [TAG_WIDTH-1:0]     tag_out
);

    localparam int OFF   = $clog2(BLOCK_BYTES);
    localparam int CNT_W = OFF + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_READ, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:OFF] r_base;
    logic [CNT_W-1:0]        r_issue_cnt;
    logic [CNT_W-1:0]        r_recv_cnt;
    logic                    r_pend;

    logic w_accept;
    logic w_active;
    logic w_issue;
    logic w_recv;
    logic w_last;
    logic w_unused_lsb;

    assign w_accept     = miss_en & rdy_in & ~flush;
    assign w_active     = (r_state == S_READ) & rdy_in & mem_gnt;
    assign w_issue      = w_active & (r_issue_cnt < CNT_W'(BLOCK_BYTES));
    assign w_recv       = w_active & r_pend;
    assign w_last       = w_recv & (r_recv_cnt == CNT_W'(BLOCK_BYTES - 1));
    assign w_unused_lsb = ^miss_pc[OFF-1:0];

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        update      = 1'b0;
        mem_wr      = 1'b0;
        mem_a       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                mem_req = 1'b1;
                if (flush)                  w_state_nxt = S_IDLE;
                else if (rdy_in && mem_gnt) w_state_nxt = S_READ;
            end
            S_READ: begin
                mem_req = 1'b1;
                if (w_issue) mem_a = {r_base, r_issue_cnt[OFF-1:0]};
                if (flush)       w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                update = 1'b1;
                if (flush || rdy_in) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_pend      <= 1'b0;
            blk_out     <= '0;
            idx_out     <= '0;
            tag_out     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_base      <= miss_pc[ADDR_WIDTH-1:OFF];
                        idx_out     <= miss_pc[OFF+INDEX_WIDTH-1:OFF];
                        tag_out     <= miss_pc[ADDR_WIDTH-1:ADDR_WIDTH-TAG_WIDTH];
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_pend      <= 1'b0;
                    end
                end
                S_READ: begin
                    if (w_active) begin
                        if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
                        r_pend <= w_issue;
                        if (w_recv) begin
                            blk_out[{r_recv_cnt[OFF-1:0], 3'b000} +: 8] <= mem_din;
                            r_recv_cnt <= r_recv_cnt + 1'b1;
                        end
                    end else begin
                        // the byte in flight is lost on a stall; fetch it again
                        r_issue_cnt <= r_recv_cnt;
                        r_pend      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: RAM returns the low address byte one cycle
// after the address, so each expected line is known by hand.
module tb_icache_refill;

    logic         clk = 1'b0;
    logic         rst_in;
    logic         rdy_in;
    logic         flush;
    logic         miss_en;
    logic [31:0]  miss_pc;
    logic         mem_req;
    logic         mem_gnt;
    logic [31:0]  mem_a;
    logic         mem_wr;
    logic [7:0]   mem_din;
    logic         update;
    logic [127:0] blk_out;
    logic [3:0]   idx_out;
    logic [23:0]  tag_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] BLK_1230 = 128'h3F3E3D3C3B3A39383736353433323130;
    localparam logic [127:0] BLK_2000 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK_ABC0 = 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0;

    icache_refill dut (
        .clk     (clk),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .flush   (flush),
        .miss_en (miss_en),
        .miss_pc (miss_pc),
        .mem_req (mem_req),
        .mem_gnt (mem_gnt),
        .mem_a   (mem_a),
        .mem_wr  (mem_wr),
        .mem_din (mem_din),
        .update  (update),
        .blk_out (blk_out),
        .idx_out (idx_out),
        .tag_out (tag_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_din <= mem_a[7:0];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered and left at 2 time units after a rising edge.
    task automatic refill(input logic [31:0] pc, input int gnt_wait, input int stall_byte,
                          input int stall_len, input int exp_lat, input logic [127:0] exp_blk,
                          input logic [3:0] exp_idx, input logic [23:0] exp_tag);
        logic [31:0] base;
        logic [31:0] seq[$];
        logic [31:0] exp_q[$];
        int          n;
        int          stall_cnt;
        int          lim;
        bit          stalled;
        bit          done;
        base      = {pc[31:4], 4'h0};
        n         = 0;
        stall_cnt = 0;
        stalled   = 1'b0;
        done      = 1'b0;
        miss_pc   = pc;
        miss_en   = 1'b1;
        rdy_in    = 1'b1;
        flush     = 1'b0;
        mem_gnt   = (gnt_wait == 0);
        @(posedge clk); #1;
        miss_en = 1'b0;
        miss_pc = 32'hFFFF_FFF0;
        while (!done && n < 60) begin
            n++;
            mem_gnt = (n > gnt_wait);
            if (stall_cnt > 0) begin
                rdy_in = 1'b0;
                stall_cnt--;
            end else begin
                rdy_in = 1'b1;
            end
            #1;
            if (update) begin
                done = 1'b1;
            end else begin
                chk("mem_req_busy", mem_req, 1'b1);
                if (mem_a != 32'h0) begin
                    seq.push_back(mem_a);
                    if (!stalled && stall_len > 0 && mem_a == base + stall_byte) begin
                        stalled   = 1'b1;
                        stall_cnt = stall_len;
                    end
                end
                @(posedge clk); #1;
            end
        end
        chk("update_seen", done, 1'b1);
        chk("latency", n, exp_lat);
        chk("mem_req_done", mem_req, 1'b0);
        chk("mem_wr", mem_wr, 1'b0);
        chk("blk_out", blk_out, exp_blk);
        chk("idx_out", idx_out, exp_idx);
        chk("tag_out", tag_out, exp_tag);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(base + i);
            if (stall_len > 0 && i == stall_byte) exp_q.push_back(base + i);
        end
        chk("issue_count", seq.size(), exp_q.size());
        lim = (seq.size() < exp_q.size()) ? seq.size() : exp_q.size();
        for (int i = 0; i < lim; i++) chk("issue_addr", seq[i], exp_q[i]);
        rdy_in  = 1'b1;
        mem_gnt = 1'b1;
        @(posedge clk); #2;
        chk("update_one_cycle", update, 1'b0);
        chk("mem_req_idle", mem_req, 1'b0);
        chk("blk_hold", blk_out, exp_blk);
    endtask

    initial begin
        int  ups;
        bit  found;
        rst_in  = 1'b0;
        rdy_in  = 1'b1;
        flush   = 1'b0;
        miss_en = 1'b0;
        miss_pc = 32'h0;
        mem_gnt = 1'b0;
        #2;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_update", update, 1'b0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_blk", blk_out, 128'h0);
        chk("rst_idx", idx_out, 4'h0);
        chk("rst_tag", tag_out, 24'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_in = 1'b1;
        @(posedge clk); #2;

        refill(32'h0000_1234, 0, 0, 0, 19, BLK_1230, 4'h3, 24'h000012);
        refill(32'h0000_1234, 5, 0, 0, 24, BLK_1230, 4'h3, 24'h000012);
        refill(32'h0000_1234, 0, 6, 2, 22, BLK_1230, 4'h3, 24'h000012);

        // flush while byte 9 is being issued
        miss_pc = 32'h0000_1234;
        miss_en = 1'b1;
        mem_gnt = 1'b1;
        rdy_in  = 1'b1;
        found   = 1'b0;
        @(posedge clk); #1;
        miss_en = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (mem_a == 32'h0000_1239) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("flush_reached_b9", found, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush_mem_req", mem_req, 1'b0);
        chk("flush_update", update, 1'b0);
        ups = 0;
        repeat (25) begin
            @(posedge clk); #2;
            if (update) ups++;
        end
        chk("flush_no_update", ups, 0);
        refill(32'h0000_2000, 0, 0, 0, 19, BLK_2000, 4'h0, 24'h000020);

        // async reset in the middle of a read
        miss_pc = 32'h0000_1234;
        miss_en = 1'b1;
        @(posedge clk); #1;
        miss_en = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("pre_rst_req", mem_req, 1'b1);
        rst_in = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_update", update, 1'b0);
        chk("midrst_mem_a", mem_a, 32'h0);
        chk("midrst_blk", blk_out, 128'h0);
        chk("midrst_idx", idx_out, 4'h0);
        chk("midrst_tag", tag_out, 24'h0);
        @(negedge clk) rst_in = 1'b1;
        @(posedge clk); #2;
        refill(32'h0000_1234, 0, 0, 0, 19, BLK_1230, 4'h3, 24'h000012);
        refill(32'h0000_ABCD, 0, 0, 0, 19, BLK_ABC0, 4'hC, 24'h0000AB);

        // flush in IDLE blocks acceptance
        miss_pc = 32'h0000_1234;
        miss_en = 1'b1;
        flush   = 1'b1;
        @(posedge clk); #1;
        miss_en = 1'b0;
        flush   = 1'b0;
        #1;
        chk("idle_flush_block", mem_req, 1'b0);
        chk("idle_flush_tag", tag_out, 24'h0000AB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
